// File: rtl/keyboard_decoder.sv
// keyboard_decoder: PS/2 keyboard receiver and key decoder.
// Synchronises and deglitches the PS/2 clock, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and maps a small set of make
// codes onto a 4-bit key code, tracking E0 (extended) and F0 (break) prefixes.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ps2_clk    PS/2 device clock (asynchronous)
//   ps2_data   PS/2 device data (asynchronous)
//   key        current key code (0 = released)
//   key_valid  one-cycle pulse when key takes a new value
//   frame_err  one-cycle pulse when a frame is discarded
module keyboard_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned KEY_W  = 4;

  localparam logic [KEY_W-1:0] KEY_RELEASED = 4'd0;
  localparam logic [KEY_W-1:0] KEY_A        = 4'd1;
  localparam logic [KEY_W-1:0] KEY_S        = 4'd2;
  localparam logic [KEY_W-1:0] KEY_W_CODE   = 4'd3;
  localparam logic [KEY_W-1:0] KEY_D        = 4'd4;
  localparam logic [KEY_W-1:0] KEY_1        = 4'd5;
  localparam logic [KEY_W-1:0] KEY_2        = 4'd6;
  localparam logic [KEY_W-1:0] KEY_3        = 4'd7;
  localparam logic [KEY_W-1:0] KEY_4        = 4'd8;
  localparam logic [KEY_W-1:0] KEY_ESC      = 4'd9;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Registered state
  logic              clk_meta_q,  clk_meta_d;
  logic              clk_sync_q,  clk_sync_d;
  logic              data_meta_q, data_meta_d;
  logic              data_sync_q, data_sync_d;
  logic              filt_q,      filt_d;
  logic [FCNT_W-1:0] fcnt_q,      fcnt_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
  state_t            state_q,     state_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [7:0]        shift_q,     shift_d;
  logic              par_q,       par_d;
  logic              ext_q,       ext_d;
  logic              brk_q,       brk_d;
  logic [KEY_W-1:0]  key_q,       key_d;
  logic              key_valid_q, key_valid_d;
  logic              frame_err_q, frame_err_d;

  // Combinational helpers
  logic              strobe_c;
  logic              timeout_c;
  logic              accept_c;
  logic              map_hit_c;
  logic [KEY_W-1:0]  map_code_c;

  // Make-code lookup on the assembled byte
  always_comb begin
    map_hit_c  = 1'b1;
    map_code_c = KEY_RELEASED;
    case (shift_q)
      8'h1C:   map_code_c = KEY_A;
      8'h1B:   map_code_c = KEY_S;
      8'h1D:   map_code_c = KEY_W_CODE;
      8'h23:   map_code_c = KEY_D;
      8'h16:   map_code_c = KEY_1;
      8'h1E:   map_code_c = KEY_2;
      8'h26:   map_code_c = KEY_3;
      8'h25:   map_code_c = KEY_4;
      8'h76:   map_code_c = KEY_ESC;
      default: map_hit_c  = 1'b0;
    endcase
  end

  // Next-state: synchronisers, clock filter, frame FSM, timeout, key decode
  always_comb begin
    clk_meta_d  = ps2_clk;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data;
    data_sync_d = data_meta_q;
    filt_d      = filt_q;
    fcnt_d      = fcnt_q;
    to_cnt_d    = to_cnt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    strobe_c    = 1'b0;
    accept_c    = 1'b0;

    // Filter: level follows the synchronised clock only after FILTER_LEN
    // consecutive differing samples; the strobe is the cycle it falls.
    if (clk_sync_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
      fcnt_d   = '0;
      filt_d   = clk_sync_q;
      strobe_c = filt_q;
    end else begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end

    // Inactivity timer, only meaningful inside a frame
    timeout_c = (state_q != S_IDLE) && !strobe_c &&
                (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    if (state_q == S_IDLE || strobe_c) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (strobe_c && !data_sync_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (strobe_c) begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (strobe_c) begin
          par_d   = data_sync_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe_c) begin
          state_d = S_IDLE;
          if (data_sync_q && (^{shift_q, par_q})) begin
            accept_c = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_c) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end

    // Prefix tracking and key update on an accepted byte
    if (accept_c) begin
      if (shift_q == BYTE_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == BYTE_BRK) begin
        brk_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (map_hit_c) begin
        if (brk_q) begin
          brk_d = 1'b0;
          if (map_code_c == key_q) begin
            key_d       = KEY_RELEASED;
            key_valid_d = 1'b1;
          end
        end else if (map_code_c != key_q) begin
          key_d       = map_code_c;
          key_valid_d = 1'b1;
        end
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      to_cnt_q    <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_q       <= KEY_RELEASED;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      to_cnt_q    <= to_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// tb_keyboard_decoder: directed PS/2 frames against a behavioural key model.
module tb_keyboard_decoder;

  localparam int unsigned FLEN = 8;
  localparam int unsigned TO   = 1000;
  // stop-bit clock fall to key_valid: 2 sync flops + FLEN filter samples
  localparam int LAT = FLEN + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic       key_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  keyboard_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [3:0] m_key     = 4'd0;   // key the DUT must show now
  logic [3:0] m_key_fut = 4'd0;   // key after all frames sent so far
  bit         m_ext     = 1'b0;
  bit         m_brk     = 1'b0;
  int         exp_cyc   = -1;
  bit         exp_valid = 1'b0;
  bit         exp_err   = 1'b0;
  logic [3:0] exp_key   = 4'd0;

  int n_valid        = 0;
  int n_err          = 0;
  int last_valid_cyc = -1;
  int stop_drive_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] map_code(input logic [7:0] b);
    case (b)
      8'h1C:   return {1'b1, 4'd1};
      8'h1B:   return {1'b1, 4'd2};
      8'h1D:   return {1'b1, 4'd3};
      8'h23:   return {1'b1, 4'd4};
      8'h16:   return {1'b1, 4'd5};
      8'h1E:   return {1'b1, 4'd6};
      8'h26:   return {1'b1, 4'd7};
      8'h25:   return {1'b1, 4'd8};
      8'h76:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // Apply one accepted byte to the model; returns whether key changes.
  function automatic bit model_accept(input logic [7:0] b);
    logic [4:0] m;
    bit v;
    m = map_code(b);
    v = 1'b0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_ext) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m[4] && m_brk) begin
      m_brk = 1'b0;
      if (m[3:0] == m_key_fut) begin
        m_key_fut = 4'd0;
        v = 1'b1;
      end
    end else if (m[4]) begin
      if (m[3:0] != m_key_fut) begin
        m_key_fut = m[3:0];
        v = 1'b1;
      end
    end else m_brk = 1'b0;
    return v;
  endfunction

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc == exp_cyc) begin
        m_key = exp_key;
        check("key_valid_event", int'(key_valid), int'(exp_valid));
        check("frame_err_event", int'(frame_err), int'(exp_err));
      end else begin
        check("key_valid_quiet", int'(key_valid), 0);
        check("frame_err_quiet", int'(frame_err), 0);
      end
      check("key", int'(key), int'(m_key));
      if (key_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (frame_err) n_err++;
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Send nbits of a frame; arm registers the outcome with the model.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit stop_bit, input int nbits, input bit arm);
    logic [10:0] bits;
    int drv;
    bits = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (20) @(negedge clk);
      ps2_clk = 1'b0;
      drv = cyc;
      if (arm && i == nbits - 1) begin
        if (nbits == 11) begin
          stop_drive_cyc = drv;
          exp_cyc = drv + LAT;
          if (stop_bit && !bad_par) begin
            exp_valid = model_accept(b);
            exp_err   = 1'b0;
          end else begin
            exp_valid = 1'b0;
            exp_err   = 1'b1;
          end
        end else begin
          exp_cyc   = drv + LAT + int'(TO);
          exp_valid = 1'b0;
          exp_err   = 1'b1;
        end
        exp_key = m_key_fut;
      end
      repeat (40) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (40) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11, 1'b1);
  endtask

  int v0;
  int e0;

  initial begin
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_key", int'(key), 0);
    check("reset_key_valid", int'(key_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Make A, then break A
    send(8'h1C);
    check("stop_to_valid_latency", last_valid_cyc - stop_drive_cyc, 10);
    check("make_A", int'(key), 1);
    v0 = n_valid;
    send(8'hF0);
    send(8'h1C);
    check("break_A", int'(key), 0);
    check("break_A_pulses", n_valid - v0, 1);

    // Typematic repeat, then break of a key not held
    v0 = n_valid;
    send(8'h1D);
    send(8'h1D);
    send(8'h1D);
    check("repeat_W", int'(key), 3);
    check("repeat_W_pulses", n_valid - v0, 1);
    v0 = n_valid;
    send(8'hF0);
    send(8'h1B);
    check("break_S_not_held", int'(key), 3);
    check("break_S_pulses", n_valid - v0, 0);

    // Bad parity then good frame
    e0 = n_err;
    send_frame(8'h76, 1'b1, 1'b1, 11, 1'b1);
    check("bad_parity_err", n_err - e0, 1);
    check("bad_parity_key", int'(key), 3);
    send(8'h76);
    check("make_esc", int'(key), 9);

    // Bad stop bit
    e0 = n_err;
    send_frame(8'h25, 1'b0, 1'b0, 11, 1'b1);
    check("bad_stop_err", n_err - e0, 1);
    check("bad_stop_key", int'(key), 9);

    // Extended prefix swallows the next code
    v0 = n_valid;
    send(8'hE0);
    send(8'h1C);
    check("ext_ignored_key", int'(key), 9);
    check("ext_ignored_pulses", n_valid - v0, 0);
    send(8'h1C);
    check("after_ext_A", int'(key), 1);

    // Sub-filter glitch with data low must not start a frame
    e0 = n_err;
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FLEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2_data = 1'b1;
    repeat (TO + 100) @(negedge clk);
    check("glitch_no_err", n_err - e0, 0);

    // Abort after 4 data bits, wait for timeout
    send_frame(8'h16, 1'b0, 1'b1, 5, 1'b1);
    repeat (TO + 100) @(negedge clk);
    check("timeout_err", n_err - e0, 1);
    check("timeout_key", int'(key), 1);
    send(8'h16);
    check("make_1", int'(key), 5);

    // Reset in the middle of a frame
    send_frame(8'h23, 1'b0, 1'b1, 4, 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    m_key     = 4'd0;
    m_key_fut = 4'd0;
    m_ext     = 1'b0;
    m_brk     = 1'b0;
    exp_cyc   = -1;
    e0 = n_err;
    v0 = n_valid;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 100) @(negedge clk);
    check("reset_mid_key", int'(key), 0);
    check("reset_mid_no_err", n_err - e0, 0);
    check("reset_mid_no_valid", n_valid - v0, 0);
    send(8'h23);
    check("make_D", int'(key), 4);

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_decoder.md
KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal clk samples of synchronised ps2_clk required before the filtered level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 65000: clk cycles without a filtered ps2_clk falling edge before an open frame is aborted.
REQ-003 clk  input  1  system clock, single clock domain (65 MHz pixel clock).
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 key  output  4  current key code: key_relesed=0000, key_A=0001, key_S=0010, key_W=0011, key_D=0100, key_1=0101, key_2=0110, key_3=0111, key_4=1000, key_esc=1001.
REQ-008 key_valid  output  1  one-cycle pulse in the cycle key takes a new value.
REQ-009 frame_err  output  1  one-cycle pulse on a discarded frame (parity, stop or timeout).

Function
REQ-010 ps2_clk and ps2_data SHALL each pass a 2-flop synchroniser before any use.
REQ-011 Filtered ps2_clk SHALL change only after FILTER_LEN consecutive identical synchronised samples; a falling edge of the filtered level is the sample strobe.
REQ-012 ps2_data SHALL be sampled (synchronised value) on the sample strobe only.
REQ-013 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: strobe with data=0 -> DATA, bit counter=0; strobe with data=1 -> stay IDLE, no error.
REQ-015 DATA: shift bit into byte register LSB first; after the 8th strobe -> PARITY.
REQ-016 PARITY: store bit; frame parity SHALL be odd over 8 data bits + parity bit; -> STOP.
REQ-017 STOP: stop bit=1 and parity good -> byte accepted, -> IDLE; otherwise frame_err pulse, byte discarded, -> IDLE.
REQ-018 In DATA/PARITY/STOP, TIMEOUT_CYCLES cycles without a strobe -> IDLE, frame_err pulse, partial byte discarded, prefix flags unchanged.
REQ-019 Accepted byte 8'hE0 SHALL set ext flag; 8'hF0 SHALL set brk flag; neither changes key.
REQ-020 Map (make codes): 1C->key_A, 1B->key_S, 1D->key_W, 23->key_D, 16->key_1, 1E->key_2, 26->key_3, 25->key_4, 76->key_esc; all others unmapped.
REQ-021 Accepted other byte with ext=1: ignored, ext and brk cleared.
REQ-022 Accepted mapped byte with brk=0, ext=0: key <= mapped code; key_valid pulses only if the value differs (typematic repeat of held key gives no pulse).
REQ-023 Accepted mapped byte with brk=1: if mapped code equals key, key <= key_relesed with key_valid pulse; else key unchanged; brk cleared.
REQ-024 Accepted unmapped byte: key unchanged, brk and ext cleared.
REQ-025 key/key_valid SHALL update on the clk edge immediately after the cycle in which the STOP strobe is processed (latency 1 cycle from stop strobe).
REQ-026 frame_err and key_valid SHALL never be asserted in the same cycle.

Reset
REQ-027 On rst_n=0, asynchronously: FSM=IDLE, bit counter=0, byte register=0, ext=brk=0, timeout counter=0, filter state=1 (idle-high), synchronisers=1, key=key_relesed, key_valid=0, frame_err=0.
REQ-028 Reset mid-frame SHALL discard the partial frame without frame_err; first strobe after release is treated as a start bit candidate.

Verification
REQ-029 Frame 1C, parity 0, stop 1 -> key=0001, key_valid one cycle after stop strobe; F0 then 1C -> key=0000 with one key_valid pulse.
REQ-030 Make 1D sent three times -> key=0011, exactly one key_valid pulse; then F0,1B (S not held) -> key stays 0011, no pulse.
REQ-031 Frame 76 with wrong parity bit (1) -> frame_err one pulse, key unchanged; following valid 76 -> key=1001.
REQ-032 E0,1C -> key unchanged, no pulse; then 1C -> key=0001 (ext cleared).
REQ-033 ps2_clk glitch low for FILTER_LEN-1 cycles in IDLE -> no strobe, FSM stays IDLE; abort after 4 data bits, wait TIMEOUT_CYCLES -> frame_err, then valid 16 -> key=0101.
REQ-034 rst_n low for 1 cycle during DATA of frame 23 -> key=0000, no frame_err, no key_valid; next full frame 23 -> key=0100.
